// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM states, owner IDs
// and the word-access func3 code used for instruction fetches.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  localparam logic [2:0] F3_LW_SW = 3'b010;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module arb_sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != WIDTH'(MAX))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access using a
// req/ready handshake, DM priority with an IF starvation guard, and an access timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [AW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [2:0]    dm_func3,
  input  logic [AW-1:0] dm_addr,
  input  logic [AW-1:0] dm_wdata,
  output logic          dm_ready,
  output logic [AW-1:0] dm_rdata,
  output logic          err,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [2:0]    mem_func3,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic [AW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int SW = cnt_width(STARVE_MAX);
  localparam int TW = cnt_width(TIMEOUT);

  arb_state_t    r_state;
  arb_owner_t    r_owner;
  logic          r_cmd_we;
  logic [2:0]    r_cmd_func3;
  logic [AW-1:0] r_cmd_addr;
  logic [AW-1:0] r_cmd_wdata;
  logic          r_mem_en;
  logic          r_if_ready;
  logic          r_dm_ready;
  logic          r_err;
  logic [AW-1:0] r_if_rdata;
  logic [AW-1:0] r_dm_rdata;

  logic          w_starved;
  logic          w_grant_if;
  logic          w_grant_dm;
  logic          w_timeout;
  logic [SW-1:0] w_starve_cnt;
  logic [TW-1:0] w_tmo_cnt;

  // IF wins a contested grant only once DM has won STARVE_MAX times in a row.
  assign w_starved  = (w_starve_cnt == SW'(STARVE_MAX));
  assign w_grant_if = (r_state == ST_IDLE) && if_req && (!dm_req || w_starved);
  assign w_grant_dm = (r_state == ST_IDLE) && dm_req && !w_grant_if;
  assign w_timeout  = (r_state == ST_ACCESS) && !mem_ack && (w_tmo_cnt == TW'(TIMEOUT - 1));

  arb_sat_counter #(
    .WIDTH (SW),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_grant_dm && if_req),
    .i_clr   (w_grant_if),
    .o_count (w_starve_cnt)
  );

  arb_sat_counter #(
    .WIDTH (TW),
    .MAX   (TIMEOUT - 1)
  ) u_tmo_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (r_state == ST_ACCESS),
    .i_clr   (r_state != ST_ACCESS),
    .o_count (w_tmo_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_cmd_we    <= 1'b0;
      r_cmd_func3 <= '0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_mem_en    <= 1'b0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
      r_err       <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_if) begin
            r_owner     <= OWN_IF;
            r_cmd_we    <= 1'b0;
            r_cmd_func3 <= F3_LW_SW;
            r_cmd_addr  <= if_addr;
            r_cmd_wdata <= '0;
            r_mem_en    <= 1'b1;
            r_state     <= ST_ACCESS;
          end else if (w_grant_dm) begin
            r_owner     <= OWN_DM;
            r_cmd_we    <= dm_we;
            r_cmd_func3 <= dm_func3;
            r_cmd_addr  <= dm_addr;
            r_cmd_wdata <= dm_wdata;
            r_mem_en    <= 1'b1;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // An ack in the timeout cycle still counts as a normal completion.
          if (mem_ack || w_timeout) begin
            r_mem_en <= 1'b0;
            r_err    <= !mem_ack;
            r_state  <= ST_RESP;
            if (r_owner == OWN_IF) begin
              r_if_ready <= 1'b1;
              r_if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              r_dm_ready <= 1'b1;
              r_dm_rdata <= (mem_ack && !r_cmd_we) ? mem_rdata : '0;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_en <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign mem_en    = r_mem_en;
  assign mem_we    = r_cmd_we;
  assign mem_func3 = r_cmd_func3;
  assign mem_addr  = r_cmd_addr;
  assign mem_wdata = r_cmd_wdata;
  assign if_ready  = r_if_ready;
  assign if_rdata  = r_if_rdata;
  assign dm_ready  = r_dm_ready;
  assign dm_rdata  = r_dm_rdata;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed handshake/arbitration/timeout
// steps followed by randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;
  localparam int AW         = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ready;
  logic [AW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [2:0]    dm_func3 = '0;
  logic [AW-1:0] dm_addr = '0;
  logic [AW-1:0] dm_wdata = '0;
  logic          dm_ready;
  logic [AW-1:0] dm_rdata;
  logic          err;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [2:0]    mem_func3;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_wdata;
  logic [AW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          accCnt = 0;
  int          memLat = 0;
  bit          memSilent = 1'b0;
  bit          strayAck = 1'b0;
  logic [31:0] memWord = '0;

  logic [2:0] ldF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] stF3 [3] = '{3'b000, 3'b001, 3'b010};

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_MAX (STARVE_MAX),
    .TIMEOUT    (TIMEOUT),
    .AW         (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_func3  (dm_func3),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ready  (dm_ready),
    .dm_rdata  (dm_rdata),
    .err       (err),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_func3 (mem_func3),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Requesters must not change their command while a request is outstanding.
  logic        prevIfReq = 1'b0, prevDmReq = 1'b0, prevIfReady = 1'b0, prevDmReady = 1'b0;
  logic [31:0] prevIfAddr = '0, prevDmAddr = '0, prevDmWdata = '0;
  always @(posedge clk) begin
    if (rst && prevIfReq && if_req && !prevIfReady && (if_addr !== prevIfAddr)) begin
      errors++;
      $error("[TB] FAIL protocol_if_addr observed=%h expected=%h", if_addr, prevIfAddr);
    end
    if (rst && prevDmReq && dm_req && !prevDmReady &&
        ((dm_addr !== prevDmAddr) || (dm_wdata !== prevDmWdata))) begin
      errors++;
      $error("[TB] FAIL protocol_dm_cmd observed=%h expected=%h", dm_addr, prevDmAddr);
    end
    prevIfReq   <= if_req;
    prevDmReq   <= dm_req;
    prevIfReady <= if_ready;
    prevDmReady <= dm_ready;
    prevIfAddr  <= if_addr;
    prevDmAddr  <= dm_addr;
    prevDmWdata <= dm_wdata;
  end

  // Advance one cycle; also plays the memory, acking on ACCESS cycle memLat+1.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_en) begin
      accCnt++;
      if (!memSilent && (accCnt == memLat + 1)) begin
        mem_ack   = 1'b1;
        mem_rdata = memWord;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      accCnt    = 0;
      mem_ack   = strayAck;
      mem_rdata = $urandom;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifR, input logic [31:0] ifA, input logic dmR,
                               input logic we, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d);
    if_addr  = ifA;
    dm_we    = we;
    dm_func3 = f3;
    dm_addr  = a;
    dm_wdata = d;
    if_req   = ifR;
    dm_req   = dmR;
  endtask

  // Cycles until either ready pulses, bounded so a hung DUT cannot stall the run.
  task automatic waitReady(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(if_ready || dm_ready) && (n < 40));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    bit          ifPend, dmPend, winIf;
    int          starve, expLat;
    logic [31:0] expAddr, expData, lastIf, lastDm, expWdata;
    logic [2:0]  expF3;
    logic        expWe;

    // Reset state
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 3'b000, 0, 0);
    rst = 1'b0;
    tick();
    tick();
    checkFlag("rst_busy", busy, 1'b0);
    checkFlag("rst_mem_en", mem_en, 1'b0);
    checkFlag("rst_if_ready", if_ready, 1'b0);
    checkFlag("rst_dm_ready", dm_ready, 1'b0);
    checkFlag("rst_err", err, 1'b0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_dm_rdata", dm_rdata, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    rst = 1'b1;
    tick();

    // IF only, L=0
    memLat = 0; memSilent = 1'b0; memWord = 32'h0050_0093;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 3'b000, 0, 0);
    tick();
    checkFlag("if_c1_en", mem_en, 1'b1);
    checkFlag("if_c1_we", mem_we, 1'b0);
    checkOutput("if_c1_f3", 32'(mem_func3), 32'd2);
    checkOutput("if_c1_addr", mem_addr, 32'h10);
    checkFlag("if_c1_ready", if_ready, 1'b0);
    tick();
    checkFlag("if_c2_ready", if_ready, 1'b1);
    checkOutput("if_c2_rdata", if_rdata, 32'h0050_0093);
    checkFlag("if_c2_err", err, 1'b0);
    checkFlag("if_c2_dm_ready", dm_ready, 1'b0);
    if_req = 1'b0;
    tick();
    checkFlag("if_c3_busy", busy, 1'b0);
    checkFlag("if_c3_ready", if_ready, 1'b0);

    // DM store, L=3: command held for four ACCESS cycles, store returns 0
    memLat = 3; memWord = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 32'h10, 1'b1, 1'b1, 3'b000, 32'h100, 32'hAB);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkFlag("st_en", mem_en, 1'b1);
      checkFlag("st_we", mem_we, 1'b1);
      checkOutput("st_wdata", mem_wdata, 32'hAB);
      checkOutput("st_addr", mem_addr, 32'h100);
      checkOutput("st_f3", 32'(mem_func3), 32'd0);
      checkFlag("st_early_ready", dm_ready, 1'b0);
    end
    tick();
    checkFlag("st_ready", dm_ready, 1'b1);
    checkOutput("st_rdata", dm_rdata, 0);
    checkFlag("st_err", err, 1'b0);
    checkOutput("st_if_rdata_hold", if_rdata, 32'h0050_0093);
    dm_req = 1'b0;
    tick();

    // Both held continuously: DM x4, IF, DM x4, IF
    memLat = 0; memWord = 32'h1234_5678;
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 3'b010, 32'h300, 0);
    for (int g = 0; g < 10; g++) begin
      tick();
      checkFlag("order_en", mem_en, 1'b1);
      checkOutput("grant_order", mem_addr, ((g % 5) == 4) ? 32'h200 : 32'h300);
      tick();
      tick();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();

    // Simultaneous requests, no starvation pressure: DM first, IF 3 cycles later
    memWord = 32'hCAFE_F00D;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 3'b100, 32'h80, 0);
    waitReady(n);
    checkOutput("sim_dm_lat", n, 2);
    checkFlag("sim_dm_ready", dm_ready, 1'b1);
    checkFlag("sim_if_not_ready", if_ready, 1'b0);
    checkOutput("sim_dm_rdata", dm_rdata, 32'hCAFE_F00D);
    dm_req = 1'b0;
    waitReady(n);
    checkOutput("sim_if_gap", n, 3);
    checkFlag("sim_if_ready", if_ready, 1'b1);
    if_req = 1'b0;
    tick();

    // No ack: timeout after 16 ACCESS cycles
    memSilent = 1'b1;
    applyStimulus(1'b0, 32'h40, 1'b1, 1'b0, 3'b010, 32'h500, 0);
    for (int k = 1; k <= 16; k++) tick();
    checkFlag("tmo_c16_en", mem_en, 1'b1);
    checkFlag("tmo_c16_ready", dm_ready, 1'b0);
    tick();
    checkFlag("tmo_ready", dm_ready, 1'b1);
    checkFlag("tmo_err", err, 1'b1);
    checkOutput("tmo_rdata", dm_rdata, 0);
    checkFlag("tmo_busy_resp", busy, 1'b1);
    dm_req = 1'b0;
    tick();
    checkFlag("tmo_busy_after", busy, 1'b0);
    checkFlag("tmo_err_after", err, 1'b0);

    // Ack on the 16th ACCESS cycle wins over the timeout
    memSilent = 1'b0; memLat = 15; memWord = 32'h0BAD_F00D;
    dm_req = 1'b1;
    waitReady(n);
    checkOutput("late_ack_lat", n, 17);
    checkFlag("late_ack_err", err, 1'b0);
    checkOutput("late_ack_rdata", dm_rdata, 32'h0BAD_F00D);
    dm_req = 1'b0;
    tick();

    // Stray ack while idle is ignored
    strayAck = 1'b1;
    tick();
    tick();
    checkFlag("stray_busy", busy, 1'b0);
    checkFlag("stray_if_ready", if_ready, 1'b0);
    checkFlag("stray_dm_ready", dm_ready, 1'b0);
    strayAck = 1'b0;
    tick();

    // Reset mid-ACCESS drops everything at once; pending requests re-arbitrate
    memSilent = 1'b1;
    applyStimulus(1'b1, 32'h600, 1'b1, 1'b1, 3'b001, 32'h700, 32'h55);
    tick();
    tick();
    tick();
    checkFlag("mid_pre_en", mem_en, 1'b1);
    rst = 1'b0;
    #1;
    checkFlag("mid_rst_en", mem_en, 1'b0);
    checkFlag("mid_rst_busy", busy, 1'b0);
    checkFlag("mid_rst_dm_ready", dm_ready, 1'b0);
    checkFlag("mid_rst_if_ready", if_ready, 1'b0);
    tick();
    rst = 1'b1;
    memSilent = 1'b0; memLat = 0; memWord = 32'h7777_0001;
    checkFlag("mid_rel_busy", busy, 1'b0);
    tick();
    checkFlag("mid_rel_en", mem_en, 1'b1);
    checkOutput("mid_rel_addr", mem_addr, 32'h700);
    waitReady(n);
    checkOutput("mid_rel_lat", n, 1);
    checkFlag("mid_rel_dm_ready", dm_ready, 1'b1);
    checkOutput("mid_rel_rdata", dm_rdata, 0);
    dm_req = 1'b0;
    waitReady(n);
    checkFlag("mid_rel_if_ready", if_ready, 1'b1);
    checkOutput("mid_rel_if_rdata", if_rdata, 32'h7777_0001);
    if_req = 1'b0;
    tick();

    // Randomized traffic against a transaction-level model
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    ifPend = 1'b0; dmPend = 1'b0; starve = 0; lastIf = '0; lastDm = '0;
    for (int t = 0; t < 40; t++) begin
      if (!ifPend && ($urandom_range(0, 99) < 60)) begin
        ifPend  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dmPend && ($urandom_range(0, 99) < 60)) begin
        dmPend   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_func3 = dm_we ? stF3[$urandom_range(0, 2)] : ldF3[$urandom_range(0, 4)];
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end
      if (!ifPend && !dmPend) begin
        ifPend  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if_req = ifPend;
      dm_req = dmPend;

      winIf = ifPend && (!dmPend || (starve == STARVE_MAX));
      if (winIf) starve = 0;
      else if (ifPend && (starve < STARVE_MAX)) starve++;

      memSilent = ($urandom_range(0, 7) == 0);
      memLat    = $urandom_range(0, 4);
      memWord   = $urandom;
      expAddr   = winIf ? if_addr : dm_addr;
      expWe     = winIf ? 1'b0 : dm_we;
      expF3     = winIf ? 3'b010 : dm_func3;
      expWdata  = dm_wdata;
      expLat    = memSilent ? TIMEOUT + 1 : memLat + 2;
      expData   = (memSilent || (!winIf && dm_we)) ? 32'h0 : memWord;
      if (winIf) lastIf = expData;
      else       lastDm = expData;

      tick();
      n = 1;
      checkFlag("rnd_en", mem_en, 1'b1);
      checkOutput("rnd_addr", mem_addr, expAddr);
      checkFlag("rnd_we", mem_we, expWe);
      checkOutput("rnd_f3", 32'(mem_func3), 32'(expF3));
      if (!winIf) checkOutput("rnd_wdata", mem_wdata, expWdata);
      while (!(if_ready || dm_ready) && (n < 40)) begin
        tick();
        n++;
        if (mem_en) checkOutput("rnd_addr_hold", mem_addr, expAddr);
      end
      checkOutput("rnd_latency", n, expLat);
      checkFlag("rnd_if_ready", if_ready, winIf);
      checkFlag("rnd_dm_ready", dm_ready, !winIf);
      checkFlag("rnd_err", err, memSilent);
      checkOutput("rnd_if_rdata", if_rdata, lastIf);
      checkOutput("rnd_dm_rdata", dm_rdata, lastDm);
      if (winIf) begin
        ifPend = 1'b0;
        if_req = 1'b0;
      end else begin
        dmPend = 1'b0;
        dm_req = 1'b0;
      end
      tick();
      checkFlag("rnd_idle_busy", busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
